spi_host_poller: RTL



---
 rtl/spi_host_poller_if.sv | 25 ++
 rtl/spi_host_poller.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/spi_host_poller_if.sv
// User-side bundle between the poller and the SPI master: transmit strobe/byte,
// slave select code, and the master's ready/receive stream.
interface spi_host_poller_if #(
    parameter int DATABITS = 8,
    parameter int SPI_SIZE = 2
);
    logic                i_TX_Ready_M;
    logic                i_RX_DV_M;
    logic [DATABITS-1:0] i_RX_Byte_M;
    logic                o_TX_DV_M;
    logic [DATABITS-1:0] o_TX_Byte_M;
    logic [SPI_SIZE-1:0] o_SPI_Code;

    // Poller side: drives transmit requests, consumes the receive stream.
    modport master (
        input  i_TX_Ready_M, i_RX_DV_M, i_RX_Byte_M,
        output o_TX_DV_M, o_TX_Byte_M, o_SPI_Code
    );

    // SPI master side of the same bundle.
    modport slave (
        output i_TX_Ready_M, i_RX_DV_M, i_RX_Byte_M,
        input  o_TX_DV_M, o_TX_Byte_M, o_SPI_Code
    );
endinterface

// File: rtl/spi_host_poller.sv
// Round-robin SPI poller: sends a read command to each slave in turn, gathers the
// response bytes and publishes the latest reading per slave with a timeout flag.
module spi_host_poller #(
    parameter int                  DATABITS   = 8,
    parameter int                  SPI_SIZE   = 2,
    parameter int                  NUM_SLAVES = 2,
    parameter int                  RESP_BYTES = 2,
    parameter logic [DATABITS-1:0] CMD_READ   = 8'hA5,
    parameter logic [DATABITS-1:0] DUMMY_BYTE = 8'h00,
    parameter int                  POLL_GAP   = 1000,
    parameter int                  TIMEOUT    = 255
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    spi_host_poller_if.master              spi,
    output logic [RESP_BYTES*DATABITS-1:0] data_s0,
    output logic [RESP_BYTES*DATABITS-1:0] data_s1,
    output logic                           valid_s0,
    output logic                           valid_s1,
    output logic [NUM_SLAVES-1:0]          err,
    output logic                           busy
);
    localparam int RESP_W = RESP_BYTES * DATABITS;
    localparam int CNT_W  = $clog2(RESP_BYTES + 2);
    localparam int GAP_W  = $clog2(POLL_GAP + 1);
    localparam int TO_W   = $clog2(TIMEOUT + 1);
    localparam int SLV_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [2:0] {IDLE, GAP, SEL, SEND, WAIT_RX, DONE, ERR} state_t;

    state_t              state_q, state_d;
    logic [SLV_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [TO_W-1:0]     to_q, to_d;
    logic [RESP_W-1:0]   asm_q, asm_d;
    logic [RESP_W-1:0]   data_q [NUM_SLAVES];
    logic [RESP_W-1:0]   data_d [NUM_SLAVES];
    logic [NUM_SLAVES-1:0] valid_q, valid_d;
    logic [NUM_SLAVES-1:0] err_q, err_d;
    logic                tx_dv_q, tx_dv_d;
    logic [DATABITS-1:0] tx_byte_q, tx_byte_d;
    logic [SPI_SIZE-1:0] code_q, code_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            gap_q     <= '0;
            to_q      <= '0;
            asm_q     <= '0;
            data_q    <= '{default: '0};
            valid_q   <= '0;
            err_q     <= '0;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= '0;
            code_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            to_q      <= to_d;
            asm_q     <= asm_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            tx_dv_q   <= tx_dv_d;
            tx_byte_q <= tx_byte_d;
            code_q    <= code_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        to_d      = to_q;
        asm_d     = asm_q;
        data_d    = data_q;
        valid_d   = '0;
        err_d     = err_q;
        tx_dv_d   = 1'b0;
        tx_byte_d = tx_byte_q;
        code_d    = code_q;

        case (state_q)
            IDLE: begin
                gap_d = '0;
                if (en) state_d = GAP;
            end
            GAP: begin
                if (!en) begin
                    state_d = IDLE;
                    gap_d   = '0;
                end else if (gap_q == GAP_W'(POLL_GAP - 1)) begin
                    state_d = SEL;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            SEL: begin
                code_d  = SPI_SIZE'(idx_q);
                cnt_d   = '0;
                state_d = SEND;
            end
            SEND: begin
                if (spi.i_TX_Ready_M) begin
                    tx_dv_d   = 1'b1;
                    tx_byte_d = (cnt_q == '0) ? CMD_READ : DUMMY_BYTE;
                    to_d      = '0;
                    state_d   = WAIT_RX;
                end
            end
            WAIT_RX: begin
                // A byte arriving on the very cycle the timeout expires still counts.
                if (spi.i_RX_DV_M) begin
                    if (cnt_q != '0)
                        asm_d = (asm_q << DATABITS) | RESP_W'(spi.i_RX_Byte_M);
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = (cnt_q == CNT_W'(RESP_BYTES)) ? DONE : SEND;
                end else if (to_q == TO_W'(TIMEOUT)) begin
                    state_d = ERR;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            DONE, ERR: begin
                if (state_q == DONE) begin
                    data_d[idx_q]  = asm_q;
                    valid_d[idx_q] = 1'b1;
                    err_d[idx_q]   = 1'b0;
                end else begin
                    err_d[idx_q] = 1'b1;
                end
                idx_d   = (idx_q == SLV_W'(NUM_SLAVES - 1)) ? '0 : idx_q + SLV_W'(1);
                gap_d   = '0;
                state_d = en ? GAP : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign spi.o_TX_DV_M   = tx_dv_q;
    assign spi.o_TX_Byte_M = tx_byte_q;
    assign spi.o_SPI_Code  = code_q;
    assign data_s0         = data_q[0];
    assign data_s1         = data_q[1];
    assign valid_s0        = valid_q[0];
    assign valid_s1        = valid_q[1];
    assign err             = err_q;
    assign busy            = (state_q != IDLE) && (state_q != GAP);
endmodule
